// File: rtl/tt_um_counter_ctrl.sv
// Command-driven 32-bit counter with terminal-count compare, one-shot or auto-reload mode,
// and a byte-wide readback port for count bytes or a status byte.
module tt_um_counter_ctrl (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_count;
    logic [31:0] r_tc;
    logic [3:0]  r_wraps;
    logic [3:0]  r_cmd_prev;

    logic [3:0]  w_cmd_edge;
    logic        w_start;
    logic        w_stop;
    logic        w_clear;
    logic        w_load;
    logic [1:0]  w_sel;
    logic        w_mode;
    logic        w_view;
    logic        w_at_tc;
    logic [7:0]  w_status;
    logic [7:0]  w_count_byte;

    assign w_cmd_edge = ui_in[3:0] & ~r_cmd_prev;
    assign w_start    = w_cmd_edge[0];
    assign w_stop     = w_cmd_edge[1];
    assign w_clear    = w_cmd_edge[2];
    assign w_load     = w_cmd_edge[3];
    assign w_sel      = ui_in[5:4];
    assign w_mode     = ui_in[6];
    assign w_view     = ui_in[7];
    assign w_at_tc    = (r_count == r_tc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_count    <= 32'd0;
            r_tc       <= 32'hFFFF_FFFF;
            r_wraps    <= 4'd0;
            r_cmd_prev <= 4'd0;
        end else begin
            // Edge history tracks the pins even while disabled, so edges seen with ena low are lost.
            r_cmd_prev <= ui_in[3:0];
            if (ena) begin
                if (w_load) begin
                    case (w_sel)
                        2'd0:    r_tc[7:0]   <= uio_in;
                        2'd1:    r_tc[15:8]  <= uio_in;
                        2'd2:    r_tc[23:16] <= uio_in;
                        default: r_tc[31:24] <= uio_in;
                    endcase
                end
                if (w_clear) begin
                    r_state <= StIdle;
                    r_count <= 32'd0;
                    r_wraps <= 4'd0;
                end else if (w_stop) begin
                    if (r_state == StRun) begin
                        r_state <= StPause;
                    end
                end else if (w_start && (r_state != StRun)) begin
                    r_state <= StRun;
                    if (r_state == StDone) begin
                        r_count <= 32'd0;
                        r_wraps <= 4'd0;
                    end
                end else if (r_state == StRun) begin
                    if (!w_at_tc) begin
                        r_count <= r_count + 32'd1;
                    end else if (!w_mode) begin
                        r_state <= StDone;
                    end else begin
                        r_count <= 32'd0;
                        r_wraps <= r_wraps + 4'd1;
                    end
                end
            end
        end
    end

    assign w_status = {r_wraps,
                       (r_state == StIdle),
                       (r_state == StDone),
                       (r_state == StPause),
                       (r_state == StRun)};

    always_comb begin
        w_count_byte = r_count[7:0];
        case (w_sel)
            2'd0:    w_count_byte = r_count[7:0];
            2'd1:    w_count_byte = r_count[15:8];
            2'd2:    w_count_byte = r_count[23:16];
            default: w_count_byte = r_count[31:24];
        endcase
    end

    assign uo_out  = w_view ? w_status : w_count_byte;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_counter_ctrl.sv
// Directed bench for tt_um_counter_ctrl: one task per scenario, hand-computed expectations.
`timescale 1ns/100ps
module tb_tt_um_counter_ctrl;

    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;
    logic       clk;
    logic       rst_n;

    int errors;
    int checks;

    logic [31:0] cnt;
    logic [7:0]  st;

    tt_um_counter_ctrl dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic read_count(output logic [31:0] v);
        logic [7:0] saved;
        saved = ui_in;
        for (int b = 0; b < 4; b++) begin
            ui_in[7]   = 1'b0;
            ui_in[5:4] = b[1:0];
            #0.5;
            v[8*b +: 8] = uo_out;
        end
        ui_in = saved;
    endtask

    task automatic read_status(output logic [7:0] v);
        logic [7:0] saved;
        saved    = ui_in;
        ui_in[7] = 1'b1;
        #0.5;
        v        = uo_out;
        ui_in    = saved;
    endtask

    task automatic load_tc(input logic [31:0] v);
        for (int b = 0; b < 4; b++) begin
            ui_in[5:4] = b[1:0];
            uio_in     = v[8*b +: 8];
            ui_in[3]   = 1'b1;
            cycle();
            ui_in[3]   = 1'b0;
            cycle();
        end
        ui_in[5:4] = 2'd0;
    endtask

    task automatic pulse(input logic [3:0] m);
        ui_in[3:0] = m;
        cycle();
        ui_in[3:0] = 4'd0;
    endtask

    task automatic test_reset();
        #3;
        read_status(st);
        checks++;
        if (st !== 8'h08) begin errors++; $display("FAIL reset_status got=%h want=08", st); end
        read_count(cnt);
        checks++;
        if (cnt !== 32'd0) begin errors++; $display("FAIL reset_count got=%h want=0", cnt); end
        checks++;
        if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            errors++; $display("FAIL uio_const got=%h/%h want=00/00", uio_out, uio_oe);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;
        cycle();
        read_status(st);
        checks++;
        if (st !== 8'h08) begin errors++; $display("FAIL post_reset_status got=%h want=08", st); end
    endtask

    task automatic test_one_shot();
        load_tc(32'd5);
        ui_in[6] = 1'b0;
        pulse(4'b0001);
        read_count(cnt);
        read_status(st);
        checks++;
        if (cnt !== 32'd0 || st !== 8'h01) begin
            errors++; $display("FAIL oneshot_start got=%h/%h want=0/01", cnt, st);
        end
        for (int i = 1; i <= 5; i++) begin
            cycle();
            read_count(cnt);
            checks++;
            if (cnt !== i) begin errors++; $display("FAIL oneshot_count got=%0d want=%0d", cnt, i); end
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            read_count(cnt);
            read_status(st);
            checks++;
            if (cnt !== 32'd5 || st !== 8'h04) begin
                errors++; $display("FAIL oneshot_done got=%h/%h want=5/04", cnt, st);
            end
        end
        pulse(4'b0100);
        read_status(st);
        checks++;
        if (st !== 8'h08) begin errors++; $display("FAIL oneshot_clear got=%h want=08", st); end
    endtask

    task automatic test_auto_reload();
        load_tc(32'd2);
        ui_in[6] = 1'b1;
        pulse(4'b0001);
        read_count(cnt);
        checks++;
        if (cnt !== 32'd0) begin errors++; $display("FAIL reload_first got=%0d want=0", cnt); end
        for (int i = 1; i <= 8; i++) begin
            cycle();
            read_count(cnt);
            checks++;
            if (cnt !== (i % 3)) begin
                errors++; $display("FAIL reload_seq got=%0d want=%0d", cnt, i % 3);
            end
        end
        cycle();
        read_status(st);
        read_count(cnt);
        checks++;
        if (st !== 8'h31 || cnt !== 32'd0) begin
            errors++; $display("FAIL reload_wrap3 got=%h/%h want=31/0", st, cnt);
        end
        pulse(4'b0100);
        ui_in[6] = 1'b0;
        read_status(st);
        checks++;
        if (st !== 8'h08) begin errors++; $display("FAIL reload_clear got=%h want=08", st); end
    endtask

    task automatic test_tc_zero();
        load_tc(32'd0);
        pulse(4'b0001);
        read_status(st);
        checks++;
        if (st !== 8'h01) begin errors++; $display("FAIL tc0_run got=%h want=01", st); end
        cycle();
        read_status(st);
        read_count(cnt);
        checks++;
        if (st !== 8'h04 || cnt !== 32'd0) begin
            errors++; $display("FAIL tc0_done got=%h/%h want=04/0", st, cnt);
        end
        ui_in[6] = 1'b1;
        pulse(4'b0001);
        read_status(st);
        checks++;
        if (st !== 8'h01) begin errors++; $display("FAIL tc0_restart got=%h want=01", st); end
        cycle();
        read_status(st);
        checks++;
        if (st !== 8'h11) begin errors++; $display("FAIL tc0_wrap1 got=%h want=11", st); end
        cycle();
        cycle();
        read_status(st);
        read_count(cnt);
        checks++;
        if (st !== 8'h31 || cnt !== 32'd0) begin
            errors++; $display("FAIL tc0_wrap3 got=%h/%h want=31/0", st, cnt);
        end
        pulse(4'b0100);
        ui_in[6] = 1'b0;
    endtask

    task automatic test_pause_resume();
        load_tc(32'd100);
        pulse(4'b0001);
        repeat (7) cycle();
        read_count(cnt);
        checks++;
        if (cnt !== 32'd7) begin errors++; $display("FAIL pause_pre got=%0d want=7", cnt); end
        ui_in[1] = 1'b1;
        cycle();
        ui_in[1] = 1'b0;
        read_count(cnt);
        read_status(st);
        checks++;
        if (cnt !== 32'd7 || st !== 8'h02) begin
            errors++; $display("FAIL pause_stop got=%0d/%h want=7/02", cnt, st);
        end
        for (int i = 0; i < 10; i++) begin
            cycle();
            read_count(cnt);
            checks++;
            if (cnt !== 32'd7) begin errors++; $display("FAIL pause_hold got=%0d want=7", cnt); end
        end
        pulse(4'b0001);
        read_count(cnt);
        read_status(st);
        checks++;
        if (cnt !== 32'd7 || st !== 8'h01) begin
            errors++; $display("FAIL pause_resume got=%0d/%h want=7/01", cnt, st);
        end
        cycle();
        read_count(cnt);
        checks++;
        if (cnt !== 32'd8) begin errors++; $display("FAIL pause_next got=%0d want=8", cnt); end
        pulse(4'b0100);
    endtask

    task automatic test_priority();
        load_tc(32'd2);
        ui_in[6] = 1'b1;
        pulse(4'b0001);
        repeat (3) cycle();
        read_status(st);
        checks++;
        if (st !== 8'h11) begin errors++; $display("FAIL prio_pre got=%h want=11", st); end
        ui_in[2:0] = 3'b111;
        cycle();
        read_status(st);
        read_count(cnt);
        checks++;
        if (st !== 8'h08 || cnt !== 32'd0) begin
            errors++; $display("FAIL prio_all got=%h/%0d want=08/0", st, cnt);
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            read_status(st);
            read_count(cnt);
            checks++;
            if (st !== 8'h08 || cnt !== 32'd0) begin
                errors++; $display("FAIL prio_level got=%h/%0d want=08/0", st, cnt);
            end
        end
        ui_in[2:0] = 3'b000;
        ui_in[6]   = 1'b0;
        cycle();
    endtask

    task automatic test_async_reset();
        load_tc(32'd100);
        pulse(4'b0001);
        repeat (3) cycle();
        read_count(cnt);
        checks++;
        if (cnt !== 32'd3) begin errors++; $display("FAIL arst_pre got=%0d want=3", cnt); end
        #1 rst_n = 1'b0;
        #1;
        read_status(st);
        read_count(cnt);
        checks++;
        if (st !== 8'h08 || cnt !== 32'd0) begin
            errors++; $display("FAIL arst_immediate got=%h/%0d want=08/0", st, cnt);
        end
        #1.5 rst_n = 1'b1;
        repeat (3) cycle();
        read_status(st);
        read_count(cnt);
        checks++;
        if (st !== 8'h08 || cnt !== 32'd0) begin
            errors++; $display("FAIL arst_no_autostart got=%h/%0d want=08/0", st, cnt);
        end
        // Counting past the old tc of 100 shows tc came back as all-ones.
        pulse(4'b0001);
        repeat (110) cycle();
        read_status(st);
        read_count(cnt);
        checks++;
        if (st !== 8'h01 || cnt !== 32'd110) begin
            errors++; $display("FAIL arst_tc_ones got=%h/%0d want=01/110", st, cnt);
        end
    endtask

    task automatic test_enable();
        ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            read_count(cnt);
            checks++;
            if (cnt !== 32'd110) begin errors++; $display("FAIL ena_hold got=%0d want=110", cnt); end
        end
        ena = 1'b1;
        cycle();
        read_count(cnt);
        checks++;
        if (cnt !== 32'd111) begin errors++; $display("FAIL ena_resume got=%0d want=111", cnt); end
        pulse(4'b0010);
        ena      = 1'b0;
        ui_in[0] = 1'b1;
        cycle();
        ui_in[0] = 1'b0;
        repeat (3) cycle();
        ena = 1'b1;
        repeat (3) cycle();
        read_status(st);
        read_count(cnt);
        checks++;
        if (st !== 8'h02 || cnt !== 32'd111) begin
            errors++; $display("FAIL ena_lost_start got=%h/%0d want=02/111", st, cnt);
        end
        pulse(4'b0001);
        read_status(st);
        checks++;
        if (st !== 8'h01) begin errors++; $display("FAIL ena_real_start got=%h want=01", st); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_tc_zero();
        test_pause_resume();
        test_priority();
        test_async_reset();
        test_enable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tt_um_counter_ctrl.md
TT_UM_COUNTER_CTRL -- requirements
Module: tt_um_counter_ctrl

Interface
REQ-001 The block SHALL have a single clock, `clk`, input, width 1, with all state updating on its rising edge.
REQ-002 The block SHALL have `rst_n`, input, width 1; reset is asynchronous and active-low.
REQ-003 `ena`, input, width 1: when low, all state SHALL be held (no commands, no counting); edge-detect registers still update.
REQ-004 `ui_in`, input, 8 bits, SHALL be decoded as:
  - [0] start
  - [1] stop
  - [2] clear
  - [3] load_tc
  - [5:4] byte select (0 = LSB)
  - [6] mode (0 one-shot, 1 auto-reload)
  - [7] view (0 counter byte, 1 status byte)
REQ-005 `uio_in`, input, 8 bits, SHALL be the terminal-count data byte written on load_tc.
REQ-006 `uo_out`, output, 8 bits, SHALL be combinational from registered state:
  - view=0: counter byte selected by ui_in[5:4].
  - view=1: status byte.
REQ-007 `uio_out` SHALL be driven constant 8'h00, and `uio_oe` SHALL be driven constant 8'h00.

Function
REQ-008 ui_in[3:0] SHALL be rising-edge detected against a one-cycle registered copy. A command SHALL act on the first clock edge where the bit is sampled 1 with the previous sample 0. Level-high without an edge SHALL have no effect.
REQ-009 Simultaneous command edges SHALL resolve by priority: clear > stop > start. load_tc SHALL be independent and MAY coincide with any of them.
REQ-010 The FSM SHALL have states IDLE, RUN, PAUSE and DONE, encoded in 2 bits.
REQ-011 FSM transitions SHALL be:
  - clear: any state -> IDLE.
  - start: IDLE -> RUN, PAUSE -> RUN, DONE -> RUN with count reset to 0.
  - stop: RUN -> PAUSE.
  - All other command/state pairs SHALL be ignored.
REQ-012 The count register SHALL be 32 bits and SHALL be cleared to 0 on clear and on IDLE entry.
REQ-013 In PAUSE, IDLE and DONE, count SHALL hold.
REQ-014 In RUN, each enabled cycle SHALL behave as follows:
  - count != tc: count <= count + 1.
  - count == tc and mode=0: state <= DONE, count holds at tc.
  - count == tc and mode=1: count <= 0, wraps <= wraps + 1 (4-bit, modulo 16), state stays RUN.
REQ-015 The count/tc comparison SHALL be an unsigned 32-bit equality on registered values. tc = 0 SHALL therefore produce DONE (mode 0) or a wrap every cycle (mode 1) with count held at 0.
REQ-016 The tc register SHALL be 32 bits. On a load_tc edge, tc byte[ui_in[5:4]] <= uio_in, in any state. The new value SHALL be used for comparison from the next cycle.
REQ-017 A load_tc edge that sets tc below the current count in RUN SHALL NOT force termination. Count SHALL continue to 2^32-1, wrap to 0 naturally, and then reach tc.
REQ-018 Mode SHALL be sampled live each cycle; it is not latched.
REQ-019 The status byte SHALL be:
  - [0] running (state==RUN)
  - [1] paused
  - [2] done
  - [3] idle
  - [7:4] wraps
REQ-020 wraps SHALL clear on clear and on DONE -> RUN, and hold otherwise, except as incremented per REQ-014.
REQ-021 Latency: with the start edge sampled at edge N, the state SHALL be RUN after N and count 1 after N+1. With the stop edge at edge M, the count value after M SHALL be held.

Reset
REQ-022 While rst_n=0, the following SHALL hold:
  - state = IDLE
  - count = 0
  - tc = 32'hFFFF_FFFF
  - wraps = 0
  - edge-detect registers = 0
  - uo_out = 8'h00 for view=0, or 8'h08 for view=1
REQ-023 Reset assertion mid-RUN SHALL take effect immediately, without waiting for a clock. After release, the block SHALL require a fresh start edge to count.

Verification
REQ-024 One-shot run: load tc=5 (bytes 05,00,00,00); pulse start; mode=0 -> count 0,1,...,5, then DONE with count held at 5; status = 8'h04.
REQ-025 Auto-reload: tc=2, mode=1, run 9 cycles after start -> count sequence 0,1,2,0,1,2,0,1,2; wraps=3 (status 8'h31 at wrap 3).
REQ-026 Pause/resume: stop at count=7 -> count holds 7 for 10 cycles, status 8'h02; start -> count 8 on the next cycle.
REQ-027 Priority: clear, stop and start rising together in RUN -> IDLE, count 0, wraps 0; holding start high afterwards does not restart the counter.
REQ-028 Async reset: pulse rst_n low for half a clock mid-RUN -> count=0, tc=FFFFFFFF, IDLE before the next clock edge.
REQ-029 ena=0 in RUN for 4 cycles -> count unchanged; a start edge issued during ena=0 is not acted upon later.
